// File: rtl/seq_divider_16bit_pkg.sv
//==============================================================================
// Module   : div_pkg
// Brief    : Shared types and constants for the sequential restoring divider.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 16;

  // Iteration counter width for a given operand width.
  function automatic int div_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DIV_CNT_WIDTH_DEFAULT = $clog2(DIV_WIDTH_DEFAULT) + 1;

endpackage

`default_nettype wire

// File: rtl/seq_divider_16bit_if.sv
//==============================================================================
// Module   : seq_divider_16bit_if
// Brief    : Start/busy/done handshake and operand/result bus of the divider.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface seq_divider_16bit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/seq_divider_16bit_trial_sub.sv
//==============================================================================
// Module   : div_trial_sub
// Brief    : (WIDTH+1)-bit trial subtractor a + ~b + 1 from rippled 4-bit CLA
//            slices; o_cout=1 means no borrow.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_trial_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  wire logic [WIDTH:0]   i_a,
  input  wire logic [WIDTH:0]   i_b,
  output logic      [WIDTH-1:0] o_diff,
  output logic                  o_cout
);

  localparam int c_n   = WIDTH + 1;
  localparam int c_nsl = (c_n + 3) / 4;

  logic [WIDTH:0] w_g;
  logic [WIDTH:0] w_p;

  assign w_g = i_a & ~i_b;
  assign w_p = i_a ^ ~i_b;

  // The top difference bit is not produced: whenever no borrow occurs it is 0.
  for (genvar s = 0; s < c_nsl; s++) begin : g_slice
    localparam int c_lo = 4 * s;
    localparam int c_nb = ((c_n - c_lo) < 4) ? (c_n - c_lo) : 4;

    logic            w_cin;
    logic            w_cout;
    logic [c_nb:1]   w_c;

    if (s == 0) begin : g_head
      assign w_cin = 1'b1;
    end else begin : g_chain
      assign w_cin = g_slice[s-1].w_cout;
    end

    assign w_c[1] = w_g[c_lo] | (w_p[c_lo] & w_cin);
    if (c_nb >= 2) begin : g_c2
      assign w_c[2] = w_g[c_lo+1] | (w_p[c_lo+1] & w_g[c_lo])
                    | (w_p[c_lo+1] & w_p[c_lo] & w_cin);
    end
    if (c_nb >= 3) begin : g_c3
      assign w_c[3] = w_g[c_lo+2] | (w_p[c_lo+2] & w_g[c_lo+1])
                    | (w_p[c_lo+2] & w_p[c_lo+1] & w_g[c_lo])
                    | (w_p[c_lo+2] & w_p[c_lo+1] & w_p[c_lo] & w_cin);
    end
    if (c_nb >= 4) begin : g_c4
      assign w_c[4] = w_g[c_lo+3] | (w_p[c_lo+3] & w_g[c_lo+2])
                    | (w_p[c_lo+3] & w_p[c_lo+2] & w_g[c_lo+1])
                    | (w_p[c_lo+3] & w_p[c_lo+2] & w_p[c_lo+1] & w_g[c_lo])
                    | (w_p[c_lo+3] & w_p[c_lo+2] & w_p[c_lo+1] & w_p[c_lo] & w_cin);
    end

    assign w_cout = w_c[c_nb];

    for (genvar k = 0; k < c_nb; k++) begin : g_sum
      if (c_lo + k < WIDTH) begin : g_bit
        if (k == 0) begin : g_lsb
          assign o_diff[c_lo+k] = w_p[c_lo+k] ^ w_cin;
        end else begin : g_upper
          assign o_diff[c_lo+k] = w_p[c_lo+k] ^ w_c[k];
        end
      end
    end
  end

  assign o_cout = g_slice[c_nsl-1].w_cout;

endmodule

`default_nettype wire

// File: rtl/seq_divider_16bit.sv
//==============================================================================
// Module   : seq_divider_16bit
// Brief    : Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_divider_16bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  seq_divider_16bit_if.slave bus
);

  localparam int                c_cnt_w = div_cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  div_state_t         r_state;
  div_state_t         w_state_next;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_zero;
  logic               w_last;
  logic [WIDTH:0]     w_trial_a;
  logic [WIDTH-1:0]   w_diff;
  logic               w_cout;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  assign w_accept = bus.start && (r_state != RUN);
  assign w_zero   = (bus.divisor == '0);
  assign w_last   = (r_count == c_last);

  // Shifted partial remainder: remainder gains the dividend MSB.
  assign w_trial_a  = {r_rem, r_quo[WIDTH-1]};
  assign w_rem_next = w_cout ? w_diff : w_trial_a[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_cout};

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_trial_sub (
    .i_a    (w_trial_a),
    .i_b    ({1'b0, r_dvs}),
    .o_diff (w_diff),
    .o_cout (w_cout)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_next = w_zero ? DONE : RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == RUN);
      r_done  <= (w_state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (r_state == RUN) begin
      r_rem   <= w_rem_next;
      r_quo   <= w_quo_next;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_quotient  <= w_quo_next;
        r_remainder <= w_rem_next;
      end
    end else if (w_accept) begin
      r_dbz <= w_zero;
      if (w_zero) begin
        r_quotient  <= '1;
        r_remainder <= bus.dividend;
      end else begin
        r_rem   <= '0;
        r_quo   <= bus.dividend;
        r_dvs   <= bus.divisor;
        r_count <= '0;
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire
